// File: rtl/lif_spike_generator.sv
// Leaky integrate-and-fire neuron: saturating 8-bit membrane, arithmetic-shift leak, refractory FSM.
// Optional LIF_SPIKE_COUNT_EN adds a saturating 16-bit spike_count output.
module lif_spike_generator #(
    parameter int REFRACT_W = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic signed [7:0]           input_current,
    input  logic signed [7:0]           threshold,
    input  logic        [2:0]           decay_shift,
    input  logic        [REFRACT_W-1:0] refractory_period,
    output logic                        spike_out,
    output logic signed [7:0]           membrane_potential,
`ifdef LIF_SPIKE_COUNT_EN
    output logic        [15:0]          spike_count,
`endif
    output logic                        in_refractory
);

    typedef enum logic {INTEGRATE = 1'b0, REFRACTORY = 1'b1} state_t;

    state_t                state_q, state_d;
    logic signed [7:0]     v_q, v_d;
    logic [REFRACT_W-1:0]  cnt_q, cnt_d;
    logic                  spike_q, spike_d;
    logic signed [7:0]     leak;
    logic signed [9:0]     sum;
    logic signed [7:0]     sat;

    function automatic logic signed [7:0] sat8(input logic signed [9:0] x);
        if (x > 10'sd127)       return 8'sd127;
        else if (x < -10'sd128) return -8'sd128;
        else                    return x[7:0];
    endfunction

    // Shift by zero would return v itself, so no-leak is an explicit case.
    assign leak = (decay_shift == 3'd0) ? 8'sd0 : (v_q >>> decay_shift);
    assign sum  = 10'(v_q) - 10'(leak) + 10'(input_current);
    assign sat  = sat8(sum);

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        spike_d = 1'b0;
        if (enable) begin
            case (state_q)
                INTEGRATE: begin
                    if (sat >= threshold) begin
                        spike_d = 1'b1;
                        v_d     = 8'sd0;
                        if (refractory_period != '0) begin
                            state_d = REFRACTORY;
                            cnt_d   = refractory_period;
                        end
                    end else begin
                        v_d = sat;
                    end
                end
                REFRACTORY: begin
                    v_d = 8'sd0;
                    if (cnt_q <= {{(REFRACT_W-1){1'b0}}, 1'b1}) begin
                        state_d = INTEGRATE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - {{(REFRACT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_d = INTEGRATE;
                    v_d     = 8'sd0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INTEGRATE;
            v_q     <= 8'sd0;
            cnt_q   <= '0;
            spike_q <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            spike_q <= spike_d;
        end
    end

`ifdef LIF_SPIKE_COUNT_EN
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (spike_d && (count_q != 16'hFFFF)) count_d = count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= 16'd0;
        else       count_q <= count_d;
    end

    assign spike_count = count_q;
`endif

    assign spike_out          = spike_q;
    assign membrane_potential = v_q;
    assign in_refractory      = (state_q == REFRACTORY);

endmodule
